// File: rtl/status_monitor_pkg.sv
// Shared types and default codes for the status-word monitor.
// The state enum and the default ALIVE/PASS/FAIL words live here so the top and benches agree.
package status_monitor_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_ALIVE = 3'd0,
    ST_RUNNING    = 3'd1,
    ST_PASS       = 3'd2,
    ST_FAIL       = 3'd3,
    ST_UNKNOWN    = 3'd4,
    ST_TIMEOUT    = 3'd5
  } mon_state_e;

  localparam logic [15:0] DEF_ALIVE_CODE = 16'h0ffe;
  localparam logic [15:0] DEF_PASS_CODE  = 16'h00d5;
  localparam logic [15:0] DEF_FAIL_CODE  = 16'h7345;

  // Non-terminal states are the only ones in which time and codes still count.
  function automatic logic is_active(input mon_state_e st);
    return (st == ST_WAIT_ALIVE) || (st == ST_RUNNING);
  endfunction

endpackage

// File: rtl/code_debounce.sv
// Synchronises an asynchronous status word and accepts a value once it has been
// sampled identically STABLE_CYCLES times in a row and differs from the last accepted one.
module code_debounce
  import status_monitor_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  output logic             acc,
  output logic [WIDTH-1:0] acc_code,
  output logic [WIDTH-1:0] last_code
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] RUN_ONE    = SW'(1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] cand_r;
  logic [SW-1:0]    cnt_r;
  logic [WIDTH-1:0] last_r;
  logic [WIDTH-1:0] code_s;
  logic [SW-1:0]    run_s;
  logic             acc_s;

  assign code_s = sync_r[SYNC_STAGES-1];

  // Run length of the current synchronised value, saturating at the threshold.
  always_comb begin
    run_s = RUN_ONE;
    acc_s = 1'b0;
    if (code_s == cand_r) begin
      if (cnt_r < STABLE_MAX) begin
        run_s = cnt_r + RUN_ONE;
      end else begin
        run_s = STABLE_MAX;
      end
    end else begin
      run_s = RUN_ONE;
    end
    acc_s = (run_s == STABLE_MAX) && (code_s != last_r);
  end

  // Synchroniser chain, run-length tracker and last accepted value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
      cand_r <= {WIDTH{1'b0}};
      cnt_r  <= {SW{1'b0}};
      last_r <= {WIDTH{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], code_in};
      cand_r <= code_s;
      cnt_r  <= run_s;
      if (acc_s) begin
        last_r <= code_s;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign acc       = acc_s;
  assign acc_code  = code_s;
  assign last_code = last_r;

endmodule

// File: rtl/status_code_monitor.sv
// Alive -> pass/fail protocol watcher over a debounced status word, with a
// saturating cycle counter, timeout and sticky registered result flags.
module status_code_monitor
  import status_monitor_pkg::*;
#(
  parameter int             WIDTH          = 16,
  parameter logic [WIDTH-1:0] ALIVE_CODE   = WIDTH'(DEF_ALIVE_CODE),
  parameter logic [WIDTH-1:0] PASS_CODE    = WIDTH'(DEF_PASS_CODE),
  parameter logic [WIDTH-1:0] FAIL_CODE    = WIDTH'(DEF_FAIL_CODE),
  parameter int             SYNC_STAGES    = 2,
  parameter int             STABLE_CYCLES  = 4,
  parameter int             TIMEOUT_CYCLES = 500000,
  localparam int            CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  input  logic             restart,
  output logic             alive,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             unknown,
  output logic             timeout,
  output logic [WIDTH-1:0] last_code,
  output logic [CW-1:0]    cycles
);

  localparam logic [CW-1:0] TMO   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  mon_state_e       state_r, state_nxt;
  logic [CW-1:0]    cycles_r, cycles_nxt, cycles_inc_s;
  logic [WIDTH-1:0] last_r, last_nxt;
  logic             alive_r, alive_nxt;
  logic             done_r, pass_r, fail_r, unknown_r, timeout_r;
  logic             expire_s;
  logic             acc_s;
  logic [WIDTH-1:0] acc_code_s;
  logic [WIDTH-1:0] filt_last_s;

  code_debounce #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .code_in  (code_in),
    .acc      (acc_s),
    .acc_code (acc_code_s),
    .last_code(filt_last_s)
  );

  // Next state; restart overrides everything, acceptance overrides expiry.
  always_comb begin
    state_nxt    = state_r;
    cycles_inc_s = (cycles_r < TMO) ? (cycles_r + C_ONE) : TMO;
    expire_s     = (cycles_inc_s == TMO);
    if (restart) begin
      state_nxt = ST_WAIT_ALIVE;
    end else begin
      case (state_r)
        ST_WAIT_ALIVE: begin
          if (acc_s && (acc_code_s == ALIVE_CODE)) begin
            state_nxt = ST_RUNNING;
          end else if (expire_s) begin
            state_nxt = ST_TIMEOUT;
          end else begin
            state_nxt = ST_WAIT_ALIVE;
          end
        end
        ST_RUNNING: begin
          if (acc_s) begin
            if (acc_code_s == PASS_CODE) begin
              state_nxt = ST_PASS;
            end else if (acc_code_s == FAIL_CODE) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_UNKNOWN;
            end
          end else if (expire_s) begin
            state_nxt = ST_TIMEOUT;
          end else begin
            state_nxt = ST_RUNNING;
          end
        end
        ST_PASS, ST_FAIL, ST_UNKNOWN, ST_TIMEOUT: state_nxt = state_r;
        default: state_nxt = ST_WAIT_ALIVE;
      endcase
    end
  end

  // Counter, reported code and alive flag follow the state decision.
  always_comb begin
    cycles_nxt = cycles_r;
    last_nxt   = last_r;
    alive_nxt  = alive_r;
    if (restart) begin
      cycles_nxt = {CW{1'b0}};
      alive_nxt  = 1'b0;
    end else if (is_active(state_r)) begin
      cycles_nxt = cycles_inc_s;
      if (acc_s) begin
        last_nxt = acc_code_s;
      end else begin
        last_nxt = last_r;
      end
      alive_nxt = alive_r | ((state_r == ST_WAIT_ALIVE) && (state_nxt == ST_RUNNING));
    end else begin
      cycles_nxt = cycles_r;
    end
  end

  // State, counter and all reported flags are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_WAIT_ALIVE;
      cycles_r  <= {CW{1'b0}};
      last_r    <= {WIDTH{1'b0}};
      alive_r   <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      unknown_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cycles_r  <= cycles_nxt;
      last_r    <= last_nxt;
      alive_r   <= alive_nxt;
      done_r    <= !is_active(state_nxt);
      pass_r    <= (state_nxt == ST_PASS);
      fail_r    <= (state_nxt == ST_FAIL);
      unknown_r <= (state_nxt == ST_UNKNOWN);
      timeout_r <= (state_nxt == ST_TIMEOUT);
    end
  end

  assign alive     = alive_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign unknown   = unknown_r;
  assign timeout   = timeout_r;
  assign last_code = last_r;
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_status_code_monitor.sv
// Bench for status_code_monitor: directed protocol steps plus random code streams
// compared each cycle against a history-window reference model.
module tb_status_code_monitor;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int TMO    = 1000;
  localparam logic [15:0] C_ALIVE = 16'h0ffe;
  localparam logic [15:0] C_PASS  = 16'h00d5;
  localparam logic [15:0] C_FAIL  = 16'h7345;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic [15:0] code_in = 16'h0000;
  logic        restart = 1'b0;
  logic        alive, done, pass, fail, unknown, timeout;
  logic [15:0] last_code;
  logic [9:0]  cycles;

  logic        reset8 = 1'b1;
  logic [7:0]  code8 = 8'h00;
  logic        restart8 = 1'b0;
  logic        alive8, done8, pass8, fail8, unknown8, timeout8;
  logic [7:0]  last8;
  logic [7:0]  cycles8;

  status_code_monitor #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .code_in(code_in), .restart(restart),
    .alive(alive), .done(done), .pass(pass), .fail(fail), .unknown(unknown),
    .timeout(timeout), .last_code(last_code), .cycles(cycles)
  );

  status_code_monitor #(.WIDTH(8), .ALIVE_CODE(8'h5a), .PASS_CODE(8'ha5),
                        .FAIL_CODE(8'h3c), .TIMEOUT_CYCLES(200)) dut8 (
    .clock(clock), .reset(reset8), .code_in(code8), .restart(restart8),
    .alive(alive8), .done(done8), .pass(pass8), .fail(fail8), .unknown(unknown8),
    .timeout(timeout8), .last_code(last8), .cycles(cycles8)
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  string phase = "init";

  // Reference model: raw captured history plus protocol outcome (0 none, 1 pass, 2 fail, 3 unknown, 4 timeout).
  logic [15:0] hist[$];
  logic [15:0] f_last;
  logic [15:0] m_last;
  bit          m_alive;
  int          m_cyc;
  int          result;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {32'd0, alive, done, pass, fail, unknown, timeout, last_code, cycles};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {32'd0, m_alive, (result != 0), (result == 1), (result == 2), (result == 3),
            (result == 4), m_last, 10'(m_cyc)};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC + STABLE; i++) hist.push_back(16'h0000);
    f_last = 16'h0000; m_last = 16'h0000; m_alive = 1'b0; m_cyc = 0; result = 0;
  endtask

  task automatic model_edge(input logic [15:0] v, input bit rs);
    int n;
    logic [15:0] s;
    bit acc;
    bit became;
    hist.push_back(v);
    if (hist.size() > 32) hist.delete(0);
    n = hist.size();
    s = hist[n-1-SYNC];
    acc = (s != f_last);
    for (int k = 1; k < STABLE; k++) if (hist[n-1-SYNC-k] != s) acc = 1'b0;
    if (acc) f_last = s;
    became = 1'b0;
    if (rs) begin
      result = 0; m_alive = 1'b0; m_cyc = 0;
    end else if (result == 0) begin
      m_cyc = (m_cyc < TMO) ? m_cyc + 1 : TMO;
      if (acc) begin
        m_last = s;
        if (!m_alive) begin
          if (s == C_ALIVE) begin m_alive = 1'b1; became = 1'b1; end
        end else begin
          result = (s == C_PASS) ? 1 : (s == C_FAIL) ? 2 : 3;
        end
      end
      if (result == 0 && !became && m_cyc == TMO) result = 4;
    end
  endtask

  // One clock: inputs set at the falling edge, model stepped at the rising edge, outputs checked at the next fall.
  task automatic step(input logic [15:0] v, input bit rs);
    code_in = v;
    restart = rs;
    @(posedge clock);
    model_edge(v, rs);
    edge_n++;
    @(negedge clock);
    restart = 1'b0;
    check(phase, obs_vec(), exp_vec());
  endtask

  task automatic run_to(input int target, input logic [15:0] v);
    while (edge_n < target) step(v, 1'b0);
  endtask

  task automatic hold(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; code_in = 16'h0000; restart = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", obs_vec(), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    logic [15:0] val;
    int len;

    // Basic pass: alive 5 edges after capture, pass likewise, counter frozen.
    do_reset();
    phase = "basic";
    run_to(9, 16'h0000);
    run_to(14, C_ALIVE);
    check("alive_edge14", {63'd0, alive}, 64'd0);
    step(C_ALIVE, 1'b0);
    check("alive_edge15", {63'd0, alive}, 64'd1);
    run_to(99, C_ALIVE);
    run_to(104, C_PASS);
    check("pass_edge104", {62'd0, pass, done}, 64'd0);
    step(C_PASS, 1'b0);
    check("pass_edge105", {32'd0, pass, done, last_code, 4'd0, cycles}, {32'd0, 1'b1, 1'b1, 16'h00d5, 4'd0, 10'd105});
    hold(10, C_PASS);
    check("cycles_frozen", {54'd0, cycles}, 64'd105);

    // Restart clears results; new sequence passes again.
    phase = "restart";
    step(C_PASS, 1'b1);
    check("restart_clears", {48'd0, alive, done, pass, fail, unknown, timeout, cycles}, 64'd0);
    hold(8, 16'h0000);
    hold(8, C_ALIVE);
    hold(8, C_PASS);
    check("pass_again", {62'd0, pass, done}, 64'd3);

    // Fail and unknown outcomes.
    phase = "fail";
    step(C_PASS, 1'b1);
    hold(8, C_ALIVE);
    hold(8, C_FAIL);
    check("fail_flag", {60'd0, fail, pass, unknown, done}, 64'h9);
    phase = "unknown";
    step(C_FAIL, 1'b1);
    hold(8, C_ALIVE);
    hold(8, 16'h1234);
    check("unknown_flag", {32'd0, unknown, done, 14'd0, last_code}, {32'd0, 1'b1, 1'b1, 14'd0, 16'h1234});

    // Glitch of three samples is never accepted.
    phase = "glitch";
    step(16'h1234, 1'b1);
    hold(8, C_ALIVE);
    hold(3, C_PASS);
    hold(10, C_ALIVE);
    check("glitch_rejected", {32'd0, alive, done, pass, 13'd0, last_code}, {32'd0, 1'b1, 1'b0, 1'b0, 13'd0, 16'h0ffe});

    // Random code streams with occasional restarts.
    phase = "random";
    for (int r = 0; r < 6; r++) begin
      step(code_in, 1'b1);
      for (int s = 0; s < 12; s++) begin
        case ($urandom_range(0, 5))
          0, 5:    val = C_ALIVE;
          1:       val = C_PASS;
          2:       val = C_FAIL;
          3:       val = 16'h0000;
          default: val = 16'($urandom);
        endcase
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) step(val, ($urandom_range(0, 79) == 0));
      end
    end

    // Timeout with no alive: expires exactly on edge 1000.
    do_reset();
    phase = "timeout";
    run_to(999, 16'h0000);
    check("timeout_edge999", {63'd0, timeout}, 64'd0);
    step(16'h0000, 1'b0);
    check("timeout_edge1000", {52'd0, timeout, done, cycles}, {52'd0, 1'b1, 1'b1, 10'd1000});
    hold(3, 16'h0000);
    check("timeout_saturate", {54'd0, cycles}, 64'd1000);

    // Pass accepted on the expiry edge wins over timeout.
    do_reset();
    phase = "accept_wins";
    run_to(9, 16'h0000);
    run_to(994, C_ALIVE);
    run_to(1000, C_PASS);
    check("accept_wins", {52'd0, pass, timeout, cycles}, {52'd0, 1'b1, 1'b0, 10'd1000});

    // Asynchronous reset mid-RUNNING clears outputs before any edge.
    do_reset();
    phase = "mid_reset";
    run_to(9, 16'h0000);
    run_to(30, C_ALIVE);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", obs_vec(), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    edge_n = 0;

    // 8-bit instance completes a pass sequence.
    @(negedge clock);
    reset8 = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      code8 = (e >= 40) ? 8'ha5 : (e >= 10) ? 8'h5a : 8'h00;
      @(posedge clock);
      @(negedge clock);
      if (e == 14) check("w8_alive_edge14", {63'd0, alive8}, 64'd0);
      if (e == 15) check("w8_alive_edge15", {63'd0, alive8}, 64'd1);
      if (e == 44) check("w8_pass_edge44", {63'd0, pass8}, 64'd0);
      if (e == 45) check("w8_pass_edge45", {46'd0, pass8, done8, last8, cycles8},
                         {46'd0, 1'b1, 1'b1, 8'ha5, 8'd45});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/status_code_monitor.md
# status_code_monitor

Parametrised watcher for a multi-bit status word driven by firmware on user GPIOs (e.g. the 16 checkbits on mprj_io[31:16]). It synchronises and debounces the word, tracks an alive → pass/fail protocol with a cycle-accurate timeout, and reports sticky result flags plus the captured code and the elapsed cycle count. It is synthesisable, so it serves both as a bench checker and as on-chip self-test status logic.

## Interface
- WIDTH, 16: status word width.
- ALIVE_CODE, 16'h0ffe: code announcing that firmware is running.
- PASS_CODE, 16'h00d5: success code.
- FAIL_CODE, 16'h7345: failure code.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a code, ≥1.
- TIMEOUT_CYCLES, 500000: cycles from reset/restart to a timeout if no terminal code arrives; CW = $clog2(TIMEOUT_CYCLES+1).
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- code_in  in  WIDTH  raw status word, asynchronous to clock.
- restart  in  1  synchronous one-cycle pulse; re-arms the monitor.
- alive  out  1  ALIVE_CODE accepted since the last reset/restart.
- done  out  1  any terminal state reached.
- pass  out  1  terminal: PASS_CODE.
- fail  out  1  terminal: FAIL_CODE.
- unknown  out  1  terminal: unexpected code after alive.
- timeout  out  1  terminal: counter expired.
- last_code  out  WIDTH  most recently accepted code.
- cycles  out  CW  elapsed cycles; frozen on terminal.

## Operation
- Reset: all outputs 0, state WAIT_ALIVE, synchroniser and filter cleared to 0, counter 0.
- Filter: code_s is code_in after SYNC_STAGES flops. A code is accepted when code_s has held the same value for STABLE_CYCLES consecutive edges and differs from last_code. Acceptance raises an internal one-cycle acc pulse and updates last_code.
- FSM states: WAIT_ALIVE, RUNNING, PASS, FAIL, UNKNOWN, TIMEOUT.
- WAIT_ALIVE: acc with ALIVE_CODE → RUNNING, alive=1. Any other accepted code is ignored as power-up noise, but last_code still updates.
- RUNNING: acc with PASS_CODE → PASS; FAIL_CODE → FAIL; any other value → UNKNOWN.
- In WAIT_ALIVE and RUNNING, cycles increments every edge. When cycles reaches TIMEOUT_CYCLES → TIMEOUT.
- Terminal states are sticky. done=1 with exactly one of pass/fail/unknown/timeout set. cycles and last_code freeze. The filter keeps running but its result is not reported.
- restart: next edge → WAIT_ALIVE. Clears alive, done, the result flags and cycles. last_code and the filter state are kept, so a code that is already stable is not re-accepted until it changes.

## Timing
- Latency: a code_in change sampled at edge N reaches code_s at edge N+SYNC_STAGES. With no further change it is accepted, and the FSM and flags update, at edge N+SYNC_STAGES+STABLE_CYCLES−1 (default: N+5).
- A glitch shorter than STABLE_CYCLES samples is never accepted.
- Acceptance and timeout in the same cycle: acceptance wins.
- restart in the same cycle as acceptance or timeout: restart wins, and that acceptance is discarded for the FSM.
- cycles saturates at TIMEOUT_CYCLES and never wraps.
- Asynchronous reset mid-operation clears everything immediately; the first count occurs at the first edge after deassertion.

## Structure
- Package status_monitor_pkg holds the state enum (6 states, 3-bit encoding) and the default code constants ALIVE/PASS/FAIL.
- Sub-module code_debounce (WIDTH, SYNC_STAGES, STABLE_CYCLES) implements the synchroniser, stability counter, last_code register and acc pulse.
- The top level holds the FSM, the timeout counter and the flag registers.

## Test plan
- Basic pass: code_in 0 → 16'h0ffe at cycle 10, then 16'h00d5 at cycle 100 → alive at cycle 15, pass and done at cycle 105, last_code=00d5, cycles frozen.
- Fail and unknown: after alive, drive 16'h7345 → fail=1. Repeat with 16'h1234 → unknown=1, last_code=1234.
- Glitch rejection: after alive, pulse 16'h00d5 for 3 cycles, then return to 0ffe → no flags change, last_code stays 0ffe.
- Timeout: TIMEOUT_CYCLES=1000, never drive ALIVE → timeout and done at the 1000th edge after reset, cycles=1000. Same case with acceptance forced on that edge → the code result wins.
- Restart: after pass, pulse restart → all flags 0 next edge. Drive 0 then 0ffe then 00d5 → pass again.
- Async reset mid-RUNNING, then WIDTH=8 instance: assert reset at an arbitrary phase → outputs 0 immediately. The WIDTH=8 instance with ALIVE_CODE=8'h5a and PASS_CODE=8'ha5 completes a pass sequence.
